// File: rtl/moving_average_mc_if.sv
// moving_average_mc_if
//   Sample stream bundle for moving_average_mc.
//   sample_in  : NUM_CH packed unsigned samples, channel c at [c*BITS_ADC +: BITS_ADC]
//   rdy_in     : sample_in valid this cycle (all channels)
//   sample_out : decimated result, same packing as sample_in
//   rdy_out    : one-cycle pulse marking a new sample_out
//   busy       : a block is partially accumulated
//   master = sample producer / result consumer, slave = the decimator.
interface moving_average_mc_if #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned BITS_ADC = 8
);
  logic [NUM_CH*BITS_ADC-1:0] sample_in;
  logic                       rdy_in;
  logic [NUM_CH*BITS_ADC-1:0] sample_out;
  logic                       rdy_out;
  logic                       busy;

  modport master (
    output sample_in,
    output rdy_in,
    input  sample_out,
    input  rdy_out,
    input  busy
  );

  modport slave (
    input  sample_in,
    input  rdy_in,
    output sample_out,
    output rdy_out,
    output busy
  );
endinterface

// File: rtl/moving_average_mc.sv
// moving_average_mc
//   Multi-channel decimator. Blocks of DF = 2^min(k, BIT_DIFF) accepted samples
//   are reduced per channel to one output sample by average (optionally
//   rounded), max, min or pick-first. k and mode are captured at block start.
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active low
//   clear : synchronous restart, discards the partial block (wins over rdy_in)
//   k     : log2 of decimation factor (clipped to BIT_DIFF)
//   mode  : 00 average, 01 max, 10 min, 11 pick
//   bus   : sample stream (sample_in/rdy_in in, sample_out/rdy_out/busy out)
module moving_average_mc #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned BITS_ADC  = 8,
  parameter int unsigned BITS_ACUM = 12,
  parameter int unsigned ROUND     = 0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       clear,
  input  logic [$clog2(BITS_ACUM-BITS_ADC+1)-1:0]    k,
  input  logic [1:0]                                 mode,
  moving_average_mc_if.slave                         bus
);

  localparam int unsigned BIT_DIFF = BITS_ACUM - BITS_ADC;
  localparam int unsigned K_W      = $clog2(BIT_DIFF + 1);
  localparam int unsigned CNT_W    = BIT_DIFF;
  localparam int unsigned SUM_W    = BITS_ACUM + 1;
  localparam logic [SUM_W-1:0] SAT = SUM_W'((1 << BITS_ADC) - 1);

  typedef enum logic [1:0] {
    MODE_AVG  = 2'b00,
    MODE_MAX  = 2'b01,
    MODE_MIN  = 2'b10,
    MODE_PICK = 2'b11
  } mode_t;

  logic [CNT_W-1:0]     count;
  logic [K_W-1:0]       k_lat;
  mode_t                mode_lat;
  logic [BITS_ACUM-1:0] acc      [NUM_CH];

  logic [K_W-1:0]       k_in;
  logic [K_W-1:0]       k_cur;
  mode_t                mode_cur;
  logic                 first;
  logic                 last;
  logic [CNT_W:0]       df;
  logic [SUM_W-1:0]     rnd;

  logic [BITS_ADC-1:0]  samp     [NUM_CH];
  logic [BITS_ACUM-1:0] samp_w   [NUM_CH];
  logic [BITS_ACUM-1:0] add      [NUM_CH];
  logic [SUM_W-1:0]     sum      [NUM_CH];
  logic [SUM_W-1:0]     shifted  [NUM_CH];
  logic [BITS_ACUM-1:0] held     [NUM_CH];
  logic [BITS_ACUM-1:0] acc_nxt  [NUM_CH];
  logic [BITS_ADC-1:0]  res      [NUM_CH];
  logic [NUM_CH*BITS_ADC-1:0] res_flat;

  // Block control. At count 0 the incoming k/mode govern the sample being
  // taken, so a DF=1 block and the first sample of any block behave correctly
  // in the same cycle the values are latched.
  always_comb begin
    if (k > K_W'(BIT_DIFF)) k_in = K_W'(BIT_DIFF);
    else                    k_in = k;
    first    = (count == '0);
    k_cur    = first ? k_in : k_lat;
    mode_cur = first ? mode_t'(mode) : mode_lat;
    df       = (CNT_W+1)'(1) << k_cur;
    last     = ({1'b0, count} == (df - (CNT_W+1)'(1)));
    rnd      = '0;
    if ((ROUND != 0) && (k_cur != '0))
      rnd = SUM_W'(1) << (k_cur - K_W'(1));
  end

  // Per-channel datapath. The accumulator doubles as the max/min/pick
  // register; in average mode the completing sample is folded in here so the
  // result is available on the completing edge.
  always_comb begin
    res_flat = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      samp[c]    = bus.sample_in[c*BITS_ADC +: BITS_ADC];
      samp_w[c]  = {{BIT_DIFF{1'b0}}, samp[c]};
      add[c]     = acc[c] + samp_w[c];
      sum[c]     = {1'b0, add[c]} + rnd;
      shifted[c] = sum[c] >> k_cur;
      case (mode_cur)
        MODE_MAX:  held[c] = (first || (samp_w[c] > acc[c])) ? samp_w[c] : acc[c];
        MODE_MIN:  held[c] = (first || (samp_w[c] < acc[c])) ? samp_w[c] : acc[c];
        MODE_PICK: held[c] = first ? samp_w[c] : acc[c];
        default:   held[c] = samp_w[c];
      endcase
      if (mode_cur == MODE_AVG) begin
        acc_nxt[c] = add[c];
        res[c]     = (shifted[c] > SAT) ? '1 : shifted[c][BITS_ADC-1:0];
      end else begin
        acc_nxt[c] = held[c];
        res[c]     = held[c][BITS_ADC-1:0];
      end
      res_flat[c*BITS_ADC +: BITS_ADC] = res[c];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count          <= '0;
      k_lat          <= '0;
      mode_lat       <= MODE_AVG;
      for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= '0;
      bus.sample_out <= '0;
      bus.rdy_out    <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.rdy_out <= 1'b0;
      if (clear) begin
        count    <= '0;
        for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= '0;
        bus.busy <= 1'b0;
      end else if (bus.rdy_in) begin
        if (first) begin
          k_lat    <= k_in;
          mode_lat <= mode_t'(mode);
        end
        if (last) begin
          count          <= '0;
          for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= '0;
          bus.busy       <= 1'b0;
          bus.sample_out <= res_flat;
          bus.rdy_out    <= 1'b1;
        end else begin
          count    <= count + CNT_W'(1);
          for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= acc_nxt[c];
          bus.busy <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_moving_average_mc.sv
// tb_moving_average_mc
//   Two decimators (ROUND=0 and ROUND=1) share one directed stimulus stream.
//   Expected results are pushed per DUT with the cycle they must appear in;
//   a negedge monitor pops and compares whenever rdy_out is seen.
module tb_moving_average_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [2:0]  k = '0;
  logic [1:0]  mode = '0;
  logic [15:0] sample_in = '0;
  logic        rdy_in = 1'b0;

  always #5 clk = ~clk;

  moving_average_mc_if #(.NUM_CH(2), .BITS_ADC(8)) bus0 ();
  moving_average_mc_if #(.NUM_CH(2), .BITS_ADC(8)) bus1 ();

  assign bus0.sample_in = sample_in;
  assign bus0.rdy_in    = rdy_in;
  assign bus1.sample_in = sample_in;
  assign bus1.rdy_in    = rdy_in;

  moving_average_mc #(.NUM_CH(2), .BITS_ADC(8), .BITS_ACUM(12), .ROUND(0)) u_trunc (
    .clk(clk), .rst(rst), .clear(clear), .k(k), .mode(mode), .bus(bus0)
  );

  moving_average_mc #(.NUM_CH(2), .BITS_ADC(8), .BITS_ACUM(12), .ROUND(1)) u_round (
    .clk(clk), .rst(rst), .clear(clear), .k(k), .mode(mode), .bus(bus1)
  );

  typedef struct {
    logic [15:0] val;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus0.rdy_out === 1'b1) begin
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL trunc_unexpected: rdy_out with sample_out %0h, expected no pulse (cyc %0d)",
                 bus0.sample_out, cyc);
      end else begin
        e0 = q0.pop_front();
        check("trunc_value", 32'(bus0.sample_out), 32'(e0.val));
        check("trunc_cycle", 32'(cyc), 32'(e0.cyc));
      end
    end
    if (bus1.rdy_out === 1'b1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL round_unexpected: rdy_out with sample_out %0h, expected no pulse (cyc %0d)",
                 bus1.sample_out, cyc);
      end else begin
        e1 = q1.pop_front();
        check("round_value", 32'(bus1.sample_out), 32'(e1.val));
        check("round_cycle", 32'(cyc), 32'(e1.cyc));
      end
    end
  end

  task automatic send(input logic [7:0] c0, input logic [7:0] c1);
    sample_in = {c1, c0};
    rdy_in    = 1'b1;
    @(posedge clk); #1;
    rdy_in    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Called right after the completing send: the pulse belongs to this cycle.
  task automatic expect2(input logic [15:0] v_trunc, input logic [15:0] v_round);
    q0.push_back('{val: v_trunc, cyc: cyc});
    q1.push_back('{val: v_round, cyc: cyc});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    // Asynchronous reset before any clock edge
    #2 rst = 1'b0;
    #1;
    check("reset_out",  32'({bus0.sample_out, bus1.sample_out}), 32'h0);
    check("reset_ctrl", 32'({bus0.rdy_out, bus0.busy, bus1.rdy_out, bus1.busy}), 32'h0);
    idle(2);
    rst = 1'b1;
    idle(1);

    // Average of 4 with gaps between samples
    k = 3'd2; mode = 2'b00;
    send(8'd10, 8'd255); idle(2);
    send(8'd20, 8'd255);
    check("busy_mid", 32'({bus0.busy, bus1.busy}), 32'h3);
    send(8'd30, 8'd255); idle(1);
    send(8'd40, 8'd255);
    expect2({8'd255, 8'd25}, {8'd255, 8'd25});
    check("busy_done", 32'({bus0.busy, bus1.busy}), 32'h0);
    idle(2);

    // Rounding: 3,4 -> 3 truncated, 4 rounded; 0,1 -> 0 / 1
    k = 3'd1;
    send(8'd3, 8'd0);
    send(8'd4, 8'd1);
    expect2({8'd0, 8'd3}, {8'd1, 8'd4});
    idle(1);

    // Max with mode and k changed mid-block: latched values must hold
    k = 3'd2; mode = 2'b01;
    send(8'd5, 8'd100);
    send(8'd9, 8'd50);
    mode = 2'b10; k = 3'd0;
    send(8'd2, 8'd200);
    send(8'd7, 8'd1);
    expect2({8'd200, 8'd9}, {8'd200, 8'd9});
    idle(1);

    // Min
    k = 3'd2; mode = 2'b10;
    send(8'd5, 8'd100);
    send(8'd9, 8'd50);
    send(8'd2, 8'd200);
    send(8'd7, 8'd1);
    expect2({8'd1, 8'd2}, {8'd1, 8'd2});

    // Pick, back to back with the previous block
    mode = 2'b11;
    send(8'd77, 8'd33);
    send(8'd1, 8'd200);
    send(8'd2, 8'd0);
    send(8'd3, 8'd255);
    expect2({8'd33, 8'd77}, {8'd33, 8'd77});
    idle(1);

    // k beyond BIT_DIFF clips to 4: block of 16, ch0 0..15 -> 7 / 8
    k = 3'd7; mode = 2'b00;
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 8'd255);
      if (i == 15) expect2({8'd255, 8'd7}, {8'd255, 8'd8});
    end
    idle(1);

    // DF=1: every sample completes, output equals input in each mode
    k = 3'd0;
    mode = 2'b00; send(8'd12, 8'd34);  expect2({8'd34, 8'd12},  {8'd34, 8'd12});
    mode = 2'b01; send(8'd3, 8'd200);  expect2({8'd200, 8'd3},  {8'd200, 8'd3});
    mode = 2'b10; send(8'd9, 8'd1);    expect2({8'd1, 8'd9},    {8'd1, 8'd9});
    mode = 2'b11; send(8'd250, 8'd5);  expect2({8'd5, 8'd250},  {8'd5, 8'd250});
    idle(1);

    // Clear mid-block with a simultaneous rdy_in that must be dropped
    k = 3'd2; mode = 2'b00;
    send(8'd100, 8'd50);
    send(8'd100, 8'd50);
    sample_in = {8'd99, 8'd99};
    clear = 1'b1; rdy_in = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; rdy_in = 1'b0;
    check("clear_busy", 32'({bus0.busy, bus1.busy}), 32'h0);
    check("clear_hold", 32'({bus0.sample_out, bus1.sample_out}), 32'h05FA_05FA);
    send(8'd8, 8'd0);
    send(8'd8, 8'd1);
    send(8'd8, 8'd2);
    send(8'd8, 8'd3);
    expect2({8'd1, 8'd8}, {8'd2, 8'd8});
    check("busy_after_clear_block", 32'({bus0.busy, bus1.busy}), 32'h0);
    idle(1);

    // Asynchronous reset mid-block, away from any clock edge
    send(8'd50, 8'd50);
    send(8'd60, 8'd60);
    check("busy_before_rst", 32'({bus0.busy, bus1.busy}), 32'h3);
    #2 rst = 1'b0;
    #1;
    check("async_rst_out",  32'({bus0.sample_out, bus1.sample_out}), 32'h0);
    check("async_rst_ctrl", 32'({bus0.rdy_out, bus0.busy, bus1.rdy_out, bus1.busy}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    send(8'd1, 8'd250);
    send(8'd2, 8'd251);
    send(8'd3, 8'd252);
    send(8'd4, 8'd253);
    expect2({8'd251, 8'd2}, {8'd252, 8'd3});

    // Drain, bounded
    for (int i = 0; i < 20; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(posedge clk); #1;
    end
    idle(3);
    check("drain_trunc", 32'(q0.size()), 32'h0);
    check("drain_round", 32'(q1.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/moving_average_mc.md
MOVING_AVERAGE_MC -- requirements
Module: moving_average_mc

Interface
REQ-001 Parameter NUM_CH, default 2: number of parallel sample channels sharing one strobe; range 1..8.
REQ-002 Parameter BITS_ADC, default 8: width of one channel sample.
REQ-003 Parameter BITS_ACUM, default 12: per-channel accumulator width; BIT_DIFF = BITS_ACUM-BITS_ADC, at least 1.
REQ-004 Parameter ROUND, default 0: 1 = round-half-up in average mode, 0 = truncate.
REQ-005 Port clk, input, 1: fpga clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: reset; asynchronous, active-low (asserted at 0).
REQ-007 Port clear, input, 1: synchronous block restart.
REQ-008 Port k, input, $clog2(BIT_DIFF+1): log2 of decimation factor.
REQ-009 Port mode, input, 2: 00 average, 01 max, 10 min, 11 pick (first sample of block).
REQ-010 Port sample_in, input, NUM_CH*BITS_ADC: channel c occupies bits [c*BITS_ADC +: BITS_ADC]; unsigned.
REQ-011 Port rdy_in, input, 1: sample_in valid this cycle, all channels.
REQ-012 Port sample_out, output reg, NUM_CH*BITS_ADC: decimated result, same packing as sample_in.
REQ-013 Port rdy_out, output reg, 1: one-cycle pulse marking new sample_out.
REQ-014 Port busy, output reg, 1: 1 while a block is partially accumulated.

Function
REQ-015 k_eff SHALL be min(k, BIT_DIFF); DF = 2^k_eff.
REQ-016 k_eff and mode SHALL be latched into internal registers only at block start, i.e. on the first accepted rdy_in of a block; changes mid-block SHALL NOT affect the current block.
REQ-017 Sample counter SHALL count accepted rdy_in from 0 to DF-1; the sample taken at count DF-1 completes the block, and the counter returns to 0.
REQ-018 Average mode: per channel acc += sample; on completion result = (acc+sample+R) >> k_eff, with R = 2^(k_eff-1) if ROUND=1 and k_eff>0, else 0.
REQ-019 Rounding sum SHALL be computed BITS_ACUM+1 bits wide and the result saturated to 2^BITS_ADC-1.
REQ-020 Max/min modes: first sample of block SHALL initialise the register; each later sample SHALL replace it if greater (max) or smaller (min); result = final register.
REQ-021 Pick mode: result = channel value of the first sample of the block.
REQ-022 DF=1 (k_eff=0): every rdy_in SHALL complete a block; the result equals the input in all modes.
REQ-023 rdy_out SHALL rise exactly one clock after the completing rdy_in cycle, with sample_out updated on the same edge.
REQ-024 rdy_out SHALL be 0 on all other cycles.
REQ-025 sample_out SHALL hold its last value until the next completion; it SHALL NOT be zeroed.
REQ-026 rdy_in=0 SHALL freeze all state; gaps of any length between samples are legal.
REQ-027 busy SHALL be 1 when count is not 0, else 0.
REQ-028 clear=1 SHALL reset counter and accumulators and discard the partial block; no rdy_out is produced and sample_out holds.
REQ-029 clear has priority over a simultaneous rdy_in, which SHALL be dropped.
REQ-030 Accumulators SHALL never overflow: worst case DF*(2^BITS_ADC-1) fits in BITS_ACUM.

Reset
REQ-031 rst=0 SHALL asynchronously set sample_out=0, rdy_out=0, busy=0, counter=0, accumulators=0, latched k/mode=0.
REQ-032 Reset asserted mid-block SHALL discard the block.
REQ-033 After rst deasserts, the first accepted rdy_in SHALL start a new block.

Verification
REQ-034 NUM_CH=2, k=2, mode=00, ch0 samples 10,20,30,40, ch1 samples 255 x4 -> one rdy_out pulse 1 cycle after 4th rdy_in; ch0=25, ch1=255.
REQ-035 ROUND=1, k=1, mode=00, ch0 samples 3,4 -> ch0=4; with ROUND=0 -> 3.
REQ-036 k=2, mode=01, then mode changed to 10 after 2nd sample; ch0 samples 5,9,2,7 -> ch0=9 (max), because the mode is latched.
REQ-037 k=7 with BIT_DIFF=4 -> block length 16; rdy_out pulses only on the 16th rdy_in.
REQ-038 k=2, 2 samples, then clear=1 with rdy_in=1, then 4 samples 8 each -> single rdy_out, ch0=8, busy=0 afterwards.
REQ-039 rst=0 pulsed asynchronously mid-block -> outputs 0 immediately, with no clock edge needed; next 4 samples produce correct average.
